// File: rtl/assertion_violation_logger_pkg.sv
// Shared widths, defaults and entry field layout for the violation logger.
package assertion_violation_logger_pkg;

    localparam int unsigned VEC_WIDTH        = 32;
    localparam int unsigned DEFAULT_DEPTH    = 8;
    localparam int unsigned DEFAULT_TS_WIDTH = 32;

    // Entry layout is {vector, timestamp}: timestamp in the low bits.
    localparam int unsigned ENTRY_TS_LSB = 0;

    // Vector field sits directly above the timestamp field.
    function automatic int unsigned entryVecLsb(input int unsigned tsWidth);
        return ENTRY_TS_LSB + tsWidth;
    endfunction

endpackage

// File: rtl/assertion_violation_logger_fifo.sv
// Synchronous first-word-fall-through FIFO with registered storage.
module violation_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             popEff;
    logic             pushEff;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A pop on an empty FIFO is ignored; a push on a full FIFO needs a same-cycle pop.
    assign popEff  = pop && !empty;
    assign pushEff = push && (!full || popEff);
    assign rdData  = empty ? '0 : mem[rdPtr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEff) wrPtr <= wrPtr + AW'(1);
            if (popEff)  rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(pushEff) - CW'(popEff);
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (pushEff) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/assertion_violation_logger.sv
// Captures rising assertion violations with a timestamp into a drainable log.
module assertion_violation_logger
    import assertion_violation_logger_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned TS_WIDTH = DEFAULT_TS_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       assertionViolated,
    input  logic [VEC_WIDTH-1:0]       assertionsViolated,
    input  logic [VEC_WIDTH-1:0]       violationMask,
    input  logic                       logRead,
    input  logic                       clearSticky,
    output logic                       logValid,
    output logic [VEC_WIDTH-1:0]       logVector,
    output logic [TS_WIDTH-1:0]        logTimestamp,
    output logic [$clog2(DEPTH):0]     logCount,
    output logic                       logOverflow,
    output logic [VEC_WIDTH-1:0]       stickyViolations,
    output logic                       irq
);

    localparam int unsigned EW      = VEC_WIDTH + TS_WIDTH;
    localparam int unsigned VEC_LSB = entryVecLsb(TS_WIDTH);

    logic [VEC_WIDTH-1:0] masked;
    logic [VEC_WIDTH-1:0] prevMasked;
    logic [VEC_WIDTH-1:0] newBits;
    logic [TS_WIDTH-1:0]  tsCount;
    logic [EW-1:0]        pushEntry;
    logic [EW-1:0]        headEntry;
    logic                 pushReq;
    logic                 dropEvent;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 unusedSummary;

    // The fabric OR-summary is redundant with the per-assertion vector.
    assign unusedSummary = assertionViolated;

    assign masked    = assertionsViolated & ~violationMask;
    assign newBits   = masked & ~prevMasked;
    assign pushReq   = enable && (newBits != '0);
    // When full, a same-cycle read frees a slot (logRead is effective since full implies non-empty).
    assign dropEvent = pushReq && fifoFull && !logRead;
    assign pushEntry = {newBits, tsCount};

    violation_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (pushReq),
        .pop    (logRead),
        .wrData (pushEntry),
        .rdData (headEntry),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (logCount)
    );

    assign logValid     = !fifoEmpty;
    assign logVector    = headEntry[VEC_LSB +: VEC_WIDTH];
    assign logTimestamp = headEntry[ENTRY_TS_LSB +: TS_WIDTH];
    assign irq          = logValid | logOverflow;

    // Edge-detect history tracks the masked levels regardless of enable.
    always_ff @(posedge clk) begin
        if (rst) prevMasked <= '0;
        else     prevMasked <= masked;
    end

    // Free-running timestamp, paused while logging is disabled.
    always_ff @(posedge clk) begin
        if (rst)         tsCount <= '0;
        else if (enable) tsCount <= tsCount + TS_WIDTH'(1);
    end

    // Sticky summary and overflow; same-cycle set conditions win over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            stickyViolations <= '0;
            logOverflow      <= 1'b0;
        end else begin
            stickyViolations <= (clearSticky ? '0 : stickyViolations)
                              | (enable ? masked : '0);
            if (dropEvent)        logOverflow <= 1'b1;
            else if (clearSticky) logOverflow <= 1'b0;
        end
    end

endmodule
